alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised signed two's-complement ALU: two nIO-bit operands, 3-bit opcode, one registered nIO-bit result, registered overflow flag.
- Datapath leaf block; operands and opcode are sampled every clock.
- Core operations are add, subtract, max, min, bitwise AND/OR/XOR and truncated multiply.

Parameters:
- nIO, 8, operand and result width in bits (signed two's complement); legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  nIO  signed operand A
- B  input  nIO  signed operand B
- OP  input  3  operation select
- Z  output  nIO  signed result, registered
- OV  output  1  signed overflow flag, registered

Behaviour:
- Reset: while rst=1, Z=0 and OV=0 immediately, independent of clk. Reset asserted mid-operation discards any pending result. The first result after reset release appears on the first rising clk edge with rst=0.
- Latency: one cycle, no handshake. On each rising clk edge, Z/OV load f(A, B, OP) computed from the current input values. A new operation is accepted every cycle.
- Opcodes; all comparisons and arithmetic are signed:
  - 000 ADD: Z = (A+B) mod 2^nIO. OV=1 when A and B have equal sign and the result sign differs.
  - 001 SUB: Z = (A-B) mod 2^nIO. OV=1 when A and B have different sign and the result sign differs from A.
  - 010 MAX: Z = larger of A, B by signed compare; Z = A when equal. OV=0.
  - 011 MIN: Z = smaller of A, B by signed compare; Z = A when equal. OV=0.
  - 100 AND: Z = A & B. OV=0.
  - 101 OR: Z = A | B. OV=0.
  - 110 XOR: Z = A ^ B. OV=0.
  - 111 MUL: form the full 2*nIO-bit signed product; Z = low nIO bits. OV=1 when the product is outside [-2^(nIO-1), 2^(nIO-1)-1].
- Boundaries:
  - MIN/MAX never set OV and must use signed compare: -128 < 127 for nIO=8.
  - ADD/SUB wrap modulo 2^nIO.
  - SUB of most-negative minus positive overflows.
  - MUL of most-negative by -1 overflows; Z = most-negative.
- X/undefined inputs need not be handled. The output register holds its value only when inputs are held; there is no enable.

Decomposition:
- Shared package alu_pkg: localparams for the eight opcodes (OP_ADD=3'b000, OP_SUB=3'b001, OP_MAX=3'b010, OP_MIN=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110, OP_MUL=3'b111).
- One natural sub-module: alu_addsub, a combinational nIO-bit adder/subtractor producing sum and overflow. It is reused by MIN/MAX for the signed compare via the sign of A-B corrected by overflow.
- Opcode mux, multiplier and output register stay in alu.

Test Plan:
- Reset: drive rst=1 with A=5, B=3, OP=000 and toggle clk -> Z=0, OV=0. Assert rst asynchronously mid-cycle after a result is loaded -> Z drops to 0 without a clock edge.
- MIN/MAX, nIO=8:
  - OP=011, A=-128, B=127 -> Z=-128, OV=0.
  - OP=011, A=-5, B=-3 -> Z=-5.
  - OP=010, A=-5, B=-3 -> Z=-3.
  - OP=011, A=B=42 -> Z=42.
  - Then 20 random A/B pairs checked against a signed-min reference model, each one cycle after the input change.
- ADD/SUB overflow:
  - OP=000, A=100, B=50 -> Z=-106 (8'h96), OV=1.
  - OP=000, A=100, B=-50 -> Z=50, OV=0.
  - OP=001, A=-128, B=1 -> Z=127, OV=1.
  - OP=001, A=0, B=-128 -> Z=-128, OV=1.
- Logic:
  - OP=100, A=8'hF0, B=8'h3C -> Z=8'h30.
  - OP=101 on the same operands -> Z=8'hFC.
  - OP=110 on the same operands -> Z=8'hCC.
  - OV=0 for all three.
- MUL:
  - OP=111, A=16, B=8 -> Z=-128 (8'h80), OV=1.
  - OP=111, A=-16, B=8 -> Z=-128, OV=0.
  - OP=111, A=-128, B=-1 -> Z=-128, OV=1.
  - OP=111, A=-7, B=9 -> Z=-63, OV=0.
- Latency/back-to-back: change OP and operands every cycle across all eight opcodes -> each Z/OV pair appears exactly one rising edge after its inputs, with no bubbles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings for the ALU datapath.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational signed adder/subtractor with two's-complement overflow detect.
module alu_addsub #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         ov
);

  logic [N-1:0] b_eff;

  // Subtraction as a + ~b + 1, so one overflow rule covers both cases.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(N-1){1'b0}}, sub};
  assign ov    = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/alu.sv
// Signed nIO-bit ALU with one-cycle registered result and overflow flag.
module alu
  import alu_pkg::*;
#(
  parameter int nIO = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [nIO-1:0] A,
  input  logic [nIO-1:0] B,
  input  logic [2:0]     OP,
  output logic [nIO-1:0] Z,
  output logic           OV
);

  logic [nIO-1:0]         as_sum;
  logic                   as_ov;
  logic                   a_lt_b;
  logic [nIO-1:0]         and_bits;
  logic [nIO-1:0]         or_bits;
  logic [nIO-1:0]         xor_bits;
  logic signed [2*nIO-1:0] prod;
  logic                   mul_ov;
  logic [nIO-1:0]         z_next;
  logic                   ov_next;

  // Only ADD adds; SUB and the MIN/MAX compare all need A-B.
  alu_addsub #(.N(nIO)) u_addsub (
    .a   (A),
    .b   (B),
    .sub (OP != OP_ADD),
    .sum (as_sum),
    .ov  (as_ov)
  );

  // Signed A<B: sign of A-B, flipped when the subtraction overflowed.
  assign a_lt_b = as_sum[nIO-1] ^ as_ov;

  generate
    for (genvar gi = 0; gi < nIO; gi++) begin : g_logic
      assign and_bits[gi] = A[gi] & B[gi];
      assign or_bits[gi]  = A[gi] | B[gi];
      assign xor_bits[gi] = A[gi] ^ B[gi];
    end
  endgenerate

  assign prod = $signed(A) * $signed(B);
  // Product fits iff the top nIO+1 bits are all copies of the sign.
  assign mul_ov = !((&prod[2*nIO-1:nIO-1]) || !(|prod[2*nIO-1:nIO-1]));

  always_comb begin
    z_next  = '0;
    ov_next = 1'b0;
    case (OP)
      OP_ADD, OP_SUB: begin
        z_next  = as_sum;
        ov_next = as_ov;
      end
      OP_MAX:  z_next = a_lt_b ? B : A;
      OP_MIN:  z_next = a_lt_b ? A : B;
      OP_AND:  z_next = and_bits;
      OP_OR:   z_next = or_bits;
      OP_XOR:  z_next = xor_bits;
      OP_MUL: begin
        z_next  = prod[nIO-1:0];
        ov_next = mul_ov;
      end
      default: begin
        z_next  = '0;
        ov_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z  <= '0;
      OV <= 1'b0;
    end else begin
      Z  <= z_next;
      OV <= ov_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 8-bit ALU configuration.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OP;
  logic [7:0] Z;
  logic       OV;

  int checks;
  int passed;

  alu #(.nIO(8)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .OP  (OP),
    .Z   (Z),
    .OV  (OV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge, then land 1ns after the next rising edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    A  = a;
    B  = b;
    OP = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A = 8'd5; B = 8'd3; OP = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Z !== 8'h00 || OV !== 1'b0)
      $display("FAIL reset_hold: Z=%h OV=%b required Z=00 OV=0", Z, OV);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (Z !== 8'h08 || OV !== 1'b0)
      $display("FAIL reset_first_result: Z=%h OV=%b required Z=08 OV=0", Z, OV);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (Z !== 8'h00 || OV !== 1'b0)
      $display("FAIL reset_async: Z=%h OV=%b required Z=00 OV=0", Z, OV);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: checks done");
  endtask

  task automatic test_minmax();
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    logic signed [7:0] exp_min;
    drive(8'h80, 8'h7F, OP_MIN);
    checks++;
    if (Z !== 8'h80 || OV !== 1'b0)
      $display("FAIL min_-128_127: Z=%h OV=%b required Z=80 OV=0", Z, OV);
    else passed++;
    drive(8'hFB, 8'hFD, OP_MIN);
    checks++;
    if (Z !== 8'hFB || OV !== 1'b0)
      $display("FAIL min_-5_-3: Z=%h OV=%b required Z=fb OV=0", Z, OV);
    else passed++;
    drive(8'hFB, 8'hFD, OP_MAX);
    checks++;
    if (Z !== 8'hFD || OV !== 1'b0)
      $display("FAIL max_-5_-3: Z=%h OV=%b required Z=fd OV=0", Z, OV);
    else passed++;
    drive(8'd42, 8'd42, OP_MIN);
    checks++;
    if (Z !== 8'd42 || OV !== 1'b0)
      $display("FAIL min_equal: Z=%h OV=%b required Z=2a OV=0", Z, OV);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_min = (ra < rb) ? ra : rb;
      drive(ra, rb, OP_MIN);
      checks++;
      if (Z !== exp_min || OV !== 1'b0)
        $display("FAIL min_rand%0d A=%0d B=%0d: Z=%h OV=%b required Z=%h OV=0",
                 i, ra, rb, Z, OV, exp_min);
      else passed++;
    end
    $display("minmax: checks done");
  endtask

  task automatic test_addsub();
    drive(8'd100, 8'd50, OP_ADD);
    checks++;
    if (Z !== 8'h96 || OV !== 1'b1)
      $display("FAIL add_100_50: Z=%h OV=%b required Z=96 OV=1", Z, OV);
    else passed++;
    drive(8'd100, 8'hCE, OP_ADD);
    checks++;
    if (Z !== 8'd50 || OV !== 1'b0)
      $display("FAIL add_100_-50: Z=%h OV=%b required Z=32 OV=0", Z, OV);
    else passed++;
    drive(8'h80, 8'd1, OP_SUB);
    checks++;
    if (Z !== 8'h7F || OV !== 1'b1)
      $display("FAIL sub_-128_1: Z=%h OV=%b required Z=7f OV=1", Z, OV);
    else passed++;
    drive(8'd0, 8'h80, OP_SUB);
    checks++;
    if (Z !== 8'h80 || OV !== 1'b1)
      $display("FAIL sub_0_-128: Z=%h OV=%b required Z=80 OV=1", Z, OV);
    else passed++;
    $display("addsub: checks done");
  endtask

  task automatic test_logic();
    drive(8'hF0, 8'h3C, OP_AND);
    checks++;
    if (Z !== 8'h30 || OV !== 1'b0)
      $display("FAIL and: Z=%h OV=%b required Z=30 OV=0", Z, OV);
    else passed++;
    drive(8'hF0, 8'h3C, OP_OR);
    checks++;
    if (Z !== 8'hFC || OV !== 1'b0)
      $display("FAIL or: Z=%h OV=%b required Z=fc OV=0", Z, OV);
    else passed++;
    drive(8'hF0, 8'h3C, OP_XOR);
    checks++;
    if (Z !== 8'hCC || OV !== 1'b0)
      $display("FAIL xor: Z=%h OV=%b required Z=cc OV=0", Z, OV);
    else passed++;
    $display("logic: checks done");
  endtask

  task automatic test_mul();
    drive(8'd16, 8'd8, OP_MUL);
    checks++;
    if (Z !== 8'h80 || OV !== 1'b1)
      $display("FAIL mul_16_8: Z=%h OV=%b required Z=80 OV=1", Z, OV);
    else passed++;
    drive(8'hF0, 8'd8, OP_MUL);
    checks++;
    if (Z !== 8'h80 || OV !== 1'b0)
      $display("FAIL mul_-16_8: Z=%h OV=%b required Z=80 OV=0", Z, OV);
    else passed++;
    drive(8'h80, 8'hFF, OP_MUL);
    checks++;
    if (Z !== 8'h80 || OV !== 1'b1)
      $display("FAIL mul_-128_-1: Z=%h OV=%b required Z=80 OV=1", Z, OV);
    else passed++;
    drive(8'hF9, 8'd9, OP_MUL);
    checks++;
    if (Z !== 8'hC1 || OV !== 1'b0)
      $display("FAIL mul_-7_9: Z=%h OV=%b required Z=c1 OV=0", Z, OV);
    else passed++;
    $display("mul: checks done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] va   [8] = '{8'd3,  8'd10, 8'hFF, 8'hFF, 8'hAA, 8'hA0, 8'hFF, 8'd127};
    logic [7:0] vb   [8] = '{8'd4,  8'd20, 8'd1,  8'd1,  8'h0F, 8'h05, 8'h0F, 8'd127};
    logic [2:0] vop  [8] = '{OP_ADD, OP_SUB, OP_MAX, OP_MIN, OP_AND, OP_OR, OP_XOR, OP_MUL};
    logic [7:0] ez   [8] = '{8'h07, 8'hF6, 8'h01, 8'hFF, 8'h0A, 8'hA5, 8'hF0, 8'h01};
    logic       eov  [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      A = va[i]; B = vb[i]; OP = vop[i];
      if (i > 0) begin
        #1;
        checks++;
        if (Z !== ez[i-1] || OV !== eov[i-1])
          $display("FAIL b2b_hold%0d: Z=%h OV=%b required Z=%h OV=%b",
                   i, Z, OV, ez[i-1], eov[i-1]);
        else passed++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (Z !== ez[i] || OV !== eov[i])
        $display("FAIL b2b_op%0d: Z=%h OV=%b required Z=%h OV=%b",
                 i, Z, OV, ez[i], eov[i]);
      else passed++;
    end
    $display("back_to_back: checks done");
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    A = '0; B = '0; OP = OP_ADD;
    test_reset();
    test_minmax();
    test_addsub();
    test_logic();
    test_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
